// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared VGA 640x480@60 timing constants, frame-buffer
//                geometry, scanout control bundle and swap-FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Source frame buffer, shown 2x2 pixel-doubled
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;

  localparam int CNT_W    = 10;   // wide enough for 800 columns / 525 lines
  localparam int ADDR_W   = 17;   // wide enough for 320*240 addresses

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Timing-derived controls travelling alongside the pixel pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic vblank;
    logic frame_start;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0,
                                 vblank: 1'b0, frame_start: 1'b0};

  // RGB332 to RGB444 by replicating the top bits into the spare LSBs
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Free-running h/v raster counters with raw (unpipelined)
//                sync, display-enable, vblank and frame-start decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int H_ACTIVE = gpu_pkg::H_ACTIVE,
  parameter int H_FP     = gpu_pkg::H_FP,
  parameter int H_SYNC   = gpu_pkg::H_SYNC,
  parameter int H_BP     = gpu_pkg::H_BP,
  parameter int V_ACTIVE = gpu_pkg::V_ACTIVE,
  parameter int V_FP     = gpu_pkg::V_FP,
  parameter int V_SYNC   = gpu_pkg::V_SYNC,
  parameter int V_BP     = gpu_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       line_end_o,
  output logic       frame_end_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic       vblank_o,
  output logic       frame_start_o
);
  import gpu_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_L  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_L  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             line_end;

  assign line_end = (h_q == H_LAST);

  // Next raster position: h every cycle, v on h wrap
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (line_end) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Raster counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign line_end_o    = line_end;
  assign frame_end_o   = line_end && (v_q == V_LAST);
  assign hsync_o       = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync_o       = !((v_q >= VS_START) && (v_q < VS_END));
  assign de_o          = (h_q < H_ACT_L) && (v_q < V_ACT_L);
  assign vblank_o      = (v_q >= V_ACT_L);
  assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout
//  Description : Scans a 320x240 RGB332 frame buffer out as 640x480 VGA with
//                2x2 pixel doubling, a 3-stage aligned pipeline and a
//                vblank-synchronised display-buffer swap handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout #(
  parameter int H_ACTIVE = gpu_pkg::H_ACTIVE,
  parameter int H_FP     = gpu_pkg::H_FP,
  parameter int H_SYNC   = gpu_pkg::H_SYNC,
  parameter int H_BP     = gpu_pkg::H_BP,
  parameter int V_ACTIVE = gpu_pkg::V_ACTIVE,
  parameter int V_FP     = gpu_pkg::V_FP,
  parameter int V_SYNC   = gpu_pkg::V_SYNC,
  parameter int V_BP     = gpu_pkg::V_BP,
  parameter int FB_W     = gpu_pkg::FB_W,
  parameter int FB_H     = gpu_pkg::FB_H
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] fb_rd_addr,
  output logic        fb_rd_en,
  input  logic [7:0]  fb_dout,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        vblank,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        fb_sel
);
  import gpu_pkg::*;

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
  localparam logic [CNT_W-1:0]  FB_H_L   = CNT_W'(FB_H);

  logic [CNT_W-1:0]  h, v;
  logic              line_end, frame_end;
  logic              raw_hs, raw_vs, raw_de, raw_vb, raw_fs;
  ctl_t              ctl_raw, ctl_s1_q, ctl_s2_q, ctl_s3_q;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, pix_addr;
  logic              en_q;
  logic [11:0]       col_q;

  swap_state_t       state_q, state_d;
  logic              sel_q, sel_d;
  logic              ack_q, ack_d;
  logic              armed_q, armed_d;
  logic              vblank_rise;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .h_o           (h),
    .v_o           (v),
    .line_end_o    (line_end),
    .frame_end_o   (frame_end),
    .hsync_o       (raw_hs),
    .vsync_o       (raw_vs),
    .de_o          (raw_de),
    .vblank_o      (raw_vb),
    .frame_start_o (raw_fs)
  );

  assign ctl_raw = '{hsync: raw_hs, vsync: raw_vs, de: raw_de,
                     vblank: raw_vb, frame_start: raw_fs};

  // Row base = y*FB_W built by accumulation; advances after the second
  // (odd) copy of each source row so both doubled lines share one base.
  always_comb begin
    base_d = base_q;
    if (frame_end) begin
      base_d = '0;
    end else if (line_end && v[0] && ((v >> 1) < FB_H_L)) begin
      base_d = base_q + ROW_STEP;
    end
  end

  assign pix_addr = base_q + ADDR_W'(h >> 1);

  // Stage 1: fetch address/strobe; address holds outside the active area
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      base_q <= base_d;
      en_q   <= ctl_raw.de;
      if (ctl_raw.de) begin
        addr_q <= pix_addr;
      end
    end
  end

  // Stages 1-3: delay timing controls to line up with the colour register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_s1_q <= CTL_RESET;
      ctl_s2_q <= CTL_RESET;
      ctl_s3_q <= CTL_RESET;
    end else begin
      ctl_s1_q <= ctl_raw;
      ctl_s2_q <= ctl_s1_q;
      ctl_s3_q <= ctl_s2_q;
    end
  end

  // Stage 3: expand returned pixel; blank outside the active area
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else begin
      col_q <= ctl_s2_q.de ? rgb332_to_444(fb_dout) : 12'h000;
    end
  end

  // The output vblank goes high on the next cycle exactly when this holds
  assign vblank_rise = ctl_s2_q.vblank & ~ctl_s3_q.vblank;

  // Swap FSM next state: arm on request, complete at output vblank start;
  // a held request needs to drop once before it can arm again.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    armed_d = armed_q;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req && armed_q) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (vblank_rise) begin
          state_d = SWAP_IDLE;
          sel_d   = ~sel_q;
          ack_d   = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
    if (ack_d) begin
      armed_d = 1'b0;
    end else if (!swap_req) begin
      armed_d = 1'b1;
    end
  end

  // Swap FSM registers; reset discards any pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWAP_IDLE;
      sel_q   <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  assign fb_rd_addr  = addr_q;
  assign fb_rd_en    = en_q;
  assign vga_r       = col_q[11:8];
  assign vga_g       = col_q[7:4];
  assign vga_b       = col_q[3:0];
  assign hsync       = ctl_s3_q.hsync;
  assign vsync       = ctl_s3_q.vsync;
  assign de          = ctl_s3_q.de;
  assign vblank      = ctl_s3_q.vblank;
  assign frame_start = ctl_s3_q.frame_start;
  assign swap_ack    = ack_q;
  assign fb_sel      = sel_q;

endmodule
`default_nettype wire
